// File: rtl/huff_canon_encoder.sv
// Canonical Huffman encoder. Loads N_SYM (symbol, frequency) pairs, builds
// code lengths with one two-minimum merge per cycle, assigns canonical codes
// with a fixed (length, slot) scan, then streams one record per slot.
module huff_canon_encoder #(
  parameter int unsigned N_SYM  = 4,
  parameter int unsigned SYM_W  = 8,
  parameter int unsigned FREQ_W = 3,
  parameter int unsigned LEN_W  = $clog2(N_SYM),
  parameter int unsigned CODE_W = N_SYM - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SYM_W-1:0]  in_sym,
  input  logic [FREQ_W-1:0] in_freq,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SYM_W-1:0]  out_sym,
  output logic [LEN_W-1:0]  out_len,
  output logic [CODE_W-1:0] out_code,
  output logic              out_err,
  output logic              done
);

  localparam int unsigned IdxW    = $clog2(N_SYM);
  // Sum of N_SYM frequencies always fits in this width.
  localparam int unsigned WeightW = FREQ_W + IdxW;
  localparam logic [IdxW-1:0]  LastSlot = IdxW'(N_SYM - 1);
  localparam logic [LEN_W-1:0] LastLen  = LEN_W'(N_SYM - 1);

  typedef enum logic [1:0] {StLoad, StBuild, StCanon, StEmit} state_e;

  state_e state_q, state_d;

  logic [SYM_W-1:0]   sym_q    [N_SYM];
  logic [WeightW-1:0] weight_q [N_SYM];
  logic [IdxW-1:0]    group_q  [N_SYM];
  logic [LEN_W-1:0]   len_q    [N_SYM];
  logic [CODE_W-1:0]  code_q   [N_SYM];
  logic [N_SYM-1:0]   active_q;
  logic [IdxW-1:0]    cnt_q;
  logic [LEN_W-1:0]   lvl_q;
  logic [CODE_W:0]    next_code_q;
  logic               err_q;
  logic               done_q;

  logic               in_fire, out_fire, last_slot;
  logic [IdxW-1:0]    m1, m2;
  logic [WeightW-1:0] m1_w, m2_w;
  logic               m1_found, m2_found;
  int unsigned        n_active;
  logic               canon_hit;
  logic [CODE_W:0]    code_inc;

  assign in_ready  = (state_q == StLoad);
  assign out_valid = (state_q == StEmit);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_slot = (cnt_q == LastSlot);
  assign out_err   = err_q;
  assign done      = done_q;

  // Two lowest-weight active groups; strict '<' keeps ties on the lowest index.
  always_comb begin
    m1       = '0;
    m2       = '0;
    m1_w     = '0;
    m2_w     = '0;
    m1_found = 1'b0;
    m2_found = 1'b0;
    n_active = 0;
    for (int i = 0; i < N_SYM; i++) begin
      if (active_q[i]) begin
        n_active = n_active + 1;
        if (!m1_found || weight_q[i] < m1_w) begin
          m1       = IdxW'(i);
          m1_w     = weight_q[i];
          m1_found = 1'b1;
        end
      end
    end
    for (int i = 0; i < N_SYM; i++) begin
      if (active_q[i] && IdxW'(i) != m1) begin
        if (!m2_found || weight_q[i] < m2_w) begin
          m2       = IdxW'(i);
          m2_w     = weight_q[i];
          m2_found = 1'b1;
        end
      end
    end
  end

  // Canonical scan step: does the current slot take a code at this length.
  always_comb begin
    canon_hit = (len_q[cnt_q] == lvl_q);
    code_inc  = next_code_q + {{CODE_W{1'b0}}, canon_hit};
  end

  // Next-state logic for the LOAD -> BUILD -> CANON -> EMIT sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:  if (in_fire && last_slot) state_d = StBuild;
      StBuild: if (n_active <= 2) state_d = StCanon;
      StCanon: if (lvl_q == LastLen && last_slot) state_d = StEmit;
      StEmit:  if (out_fire && last_slot) state_d = StLoad;
      default: state_d = StLoad;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StLoad;
    else       state_q <= state_d;
  end

  // Slot table, counters and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_SYM; i++) begin
        sym_q[i]    <= '0;
        weight_q[i] <= '0;
        group_q[i]  <= '0;
        len_q[i]    <= '0;
        code_q[i]   <= '0;
      end
      active_q    <= '0;
      cnt_q       <= '0;
      lvl_q       <= LEN_W'(1);
      next_code_q <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= out_fire && last_slot;
      unique case (state_q)
        StLoad: begin
          if (in_fire) begin
            sym_q[cnt_q]    <= in_sym;
            weight_q[cnt_q] <= WeightW'(in_freq);
            group_q[cnt_q]  <= cnt_q;
            active_q[cnt_q] <= (in_freq != '0);
            len_q[cnt_q]    <= '0;
            code_q[cnt_q]   <= '0;
            cnt_q           <= last_slot ? '0 : cnt_q + 1'b1;
          end
        end
        StBuild: begin
          lvl_q       <= LEN_W'(1);
          next_code_q <= '0;
          if (n_active == 0) begin
            err_q <= 1'b1;
          end else if (n_active == 1) begin
            len_q[m1] <= LEN_W'(1);
          end else begin
            weight_q[m1] <= m1_w + m2_w;
            active_q[m2] <= 1'b0;
            for (int i = 0; i < N_SYM; i++) begin
              if (group_q[i] == m1 || group_q[i] == m2) begin
                len_q[i]   <= len_q[i] + 1'b1;
                group_q[i] <= m1;
              end
            end
          end
        end
        StCanon: begin
          if (canon_hit) code_q[cnt_q] <= next_code_q[CODE_W-1:0];
          if (last_slot) begin
            cnt_q       <= '0;
            lvl_q       <= lvl_q + 1'b1;
            next_code_q <= code_inc << 1;
          end else begin
            cnt_q       <= cnt_q + 1'b1;
            next_code_q <= code_inc;
          end
        end
        StEmit: begin
          if (out_fire) begin
            if (last_slot) begin
              cnt_q <= '0;
              err_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Record outputs are driven only while a record is presented.
  always_comb begin
    out_sym  = '0;
    out_len  = '0;
    out_code = '0;
    if (state_q == StEmit) begin
      out_sym  = sym_q[cnt_q];
      out_len  = len_q[cnt_q];
      out_code = code_q[cnt_q];
    end
  end

endmodule

// File: tb/tb_huff_canon_encoder.sv
// Directed bench for huff_canon_encoder (N_SYM=4). Slot 0 sits in the lowest
// bits of every packed stimulus/expectation vector.
module tb_huff_canon_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_sym;
  logic [2:0] in_freq;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sym;
  logic [1:0] out_len;
  logic [2:0] out_code;
  logic       out_err;
  logic       done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  huff_canon_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sym    (in_sym),
    .in_freq   (in_freq),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sym   (out_sym),
    .out_len   (out_len),
    .out_code  (out_code),
    .out_err   (out_err),
    .done      (done)
  );

  // Basic scenario data, reused by the back-pressure and reset tests.
  logic [31:0] b_syms  = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
  logic [11:0] b_freqs = {3'd2, 3'd1, 3'd1, 3'd5};
  logic [7:0]  b_lens  = {2'd2, 2'd3, 2'd3, 2'd1};
  logic [11:0] b_codes = {3'd2, 3'd7, 3'd6, 3'd0};

  // Returns after the handshake edge of the last pair.
  task automatic load4(input logic [31:0] syms, input logic [11:0] freqs);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_sym   = syms[8*i +: 8];
      in_freq  = freqs[3*i +: 3];
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  // Counts negedges until out_valid is seen; -1 if the budget expires.
  task automatic wait_emit(output int n);
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (out_valid) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_sym = '0; in_freq = '0;
    #2;
    checks++;
    if ({in_ready, out_valid, out_err, done} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_flags: got %b want 1000", {in_ready, out_valid, out_err, done});
    end
    checks++;
    if ({out_sym, out_len, out_code} !== 13'h0) begin
      failures++;
      $display("FAIL reset_record: got %h want 0", {out_sym, out_len, out_code});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int lat;
    load4(b_syms, b_freqs);
    wait_emit(lat);
    checks++;
    if (lat !== 16) begin
      failures++;
      $display("FAIL basic_latency: got %0d want 16", lat);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out_valid, out_err, out_sym, out_len, out_code} !==
          {2'b10, b_syms[8*i +: 8], b_lens[2*i +: 2], b_codes[3*i +: 3]}) begin
        failures++;
        $display("FAIL basic_rec%0d: got %h want %h", i,
                 {out_valid, out_err, out_sym, out_len, out_code},
                 {2'b10, b_syms[8*i +: 8], b_lens[2*i +: 2], b_codes[3*i +: 3]});
      end
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if ({done, out_valid, in_ready, out_err} !== 4'b1010) begin
      failures++;
      $display("FAIL basic_done: got %b want 1010", {done, out_valid, in_ready, out_err});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_pulse: got %b want 0", done);
    end
  endtask

  task automatic test_equal;
    int lat;
    logic [31:0] syms  = {8'h13, 8'h12, 8'h11, 8'h10};
    logic [11:0] codes = {3'd3, 3'd2, 3'd1, 3'd0};
    load4(syms, {3'd1, 3'd1, 3'd1, 3'd1});
    wait_emit(lat);
    checks++;
    if (lat !== 16) begin
      failures++;
      $display("FAIL equal_latency: got %0d want 16", lat);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out_valid, out_err, out_sym, out_len, out_code} !==
          {2'b10, syms[8*i +: 8], 2'd2, codes[3*i +: 3]}) begin
        failures++;
        $display("FAIL equal_rec%0d: got %h want %h", i,
                 {out_valid, out_err, out_sym, out_len, out_code},
                 {2'b10, syms[8*i +: 8], 2'd2, codes[3*i +: 3]});
      end
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if ({done, out_valid, in_ready} !== 3'b101) begin
      failures++;
      $display("FAIL equal_done: got %b want 101", {done, out_valid, in_ready});
    end
  endtask

  task automatic test_single;
    int lat;
    logic [31:0] syms = {8'h34, 8'h33, 8'h32, 8'h31};
    logic [7:0]  lens = {2'd0, 2'd0, 2'd1, 2'd0};
    load4(syms, {3'd0, 3'd0, 3'd4, 3'd0});
    wait_emit(lat);
    checks++;
    if (lat !== 14) begin
      failures++;
      $display("FAIL single_latency: got %0d want 14", lat);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out_valid, out_err, out_sym, out_len, out_code} !==
          {2'b10, syms[8*i +: 8], lens[2*i +: 2], 3'd0}) begin
        failures++;
        $display("FAIL single_rec%0d: got %h want %h", i,
                 {out_valid, out_err, out_sym, out_len, out_code},
                 {2'b10, syms[8*i +: 8], lens[2*i +: 2], 3'd0});
      end
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if ({done, out_valid, in_ready} !== 3'b101) begin
      failures++;
      $display("FAIL single_done: got %b want 101", {done, out_valid, in_ready});
    end
  endtask

  task automatic test_all_zero;
    int lat;
    logic [31:0] syms = {8'h44, 8'h43, 8'h42, 8'h41};
    load4(syms, 12'h000);
    wait_emit(lat);
    checks++;
    if (lat !== 14) begin
      failures++;
      $display("FAIL zero_latency: got %0d want 14", lat);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out_valid, out_err, out_sym, out_len, out_code} !==
          {2'b11, syms[8*i +: 8], 2'd0, 3'd0}) begin
        failures++;
        $display("FAIL zero_rec%0d: got %h want %h", i,
                 {out_valid, out_err, out_sym, out_len, out_code},
                 {2'b11, syms[8*i +: 8], 2'd0, 3'd0});
      end
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if ({done, out_valid, in_ready, out_err} !== 4'b1010) begin
      failures++;
      $display("FAIL zero_done: got %b want 1010", {done, out_valid, in_ready, out_err});
    end
  endtask

  task automatic test_back_pressure;
    int lat;
    load4(b_syms, b_freqs);
    wait_emit(lat);
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    in_sym    = 8'hEE;
    in_freq   = 3'd7;
    for (int c = 0; c < 5; c++) begin
      in_valid = (c % 2 == 0);
      checks++;
      if ({out_valid, in_ready, out_sym, out_len, out_code} !==
          {2'b10, b_syms[15:8], b_lens[3:2], b_codes[5:3]}) begin
        failures++;
        $display("FAIL bp_hold%0d: got %h want %h", c,
                 {out_valid, in_ready, out_sym, out_len, out_code},
                 {2'b10, b_syms[15:8], b_lens[3:2], b_codes[5:3]});
      end
      @(posedge clk); @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      checks++;
      if ({out_valid, out_sym, out_len, out_code} !==
          {1'b1, b_syms[8*i +: 8], b_lens[2*i +: 2], b_codes[3*i +: 3]}) begin
        failures++;
        $display("FAIL bp_rec%0d: got %h want %h", i,
                 {out_valid, out_sym, out_len, out_code},
                 {1'b1, b_syms[8*i +: 8], b_lens[2*i +: 2], b_codes[3*i +: 3]});
      end
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if ({done, out_valid, in_ready} !== 3'b101) begin
      failures++;
      $display("FAIL bp_done: got %b want 101", {done, out_valid, in_ready});
    end
  endtask

  task automatic test_reset_in_canon;
    int lat;
    load4(b_syms, b_freqs);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, done} !== 3'b100) begin
      failures++;
      $display("FAIL canon_reset: got %b want 100", {in_ready, out_valid, done});
    end
    @(negedge clk);
    reset = 1'b0;
    load4(b_syms, b_freqs);
    wait_emit(lat);
    checks++;
    if (lat !== 16) begin
      failures++;
      $display("FAIL reload_latency: got %0d want 16", lat);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out_valid, out_sym, out_len, out_code} !==
          {1'b1, b_syms[8*i +: 8], b_lens[2*i +: 2], b_codes[3*i +: 3]}) begin
        failures++;
        $display("FAIL reload_rec%0d: got %h want %h", i,
                 {out_valid, out_sym, out_len, out_code},
                 {1'b1, b_syms[8*i +: 8], b_lens[2*i +: 2], b_codes[3*i +: 3]});
      end
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if ({done, in_ready} !== 2'b11) begin
      failures++;
      $display("FAIL reload_done: got %b want 11", {done, in_ready});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_equal();
    test_single();
    test_all_zero();
    test_back_pressure();
    test_reset_in_canon();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
